// File: rtl/mo_inv_pkg.sv
// Shared constants and types for the Montgomery-domain inverter and its multiplier.
// R = 2^DATA_WIDTH, so the Montgomery representation of 1 is 2^DATA_WIDTH mod Q.
package mo_inv_pkg;
    localparam int DATA_WIDTH = 12;
    localparam int Q          = 3329;

    typedef logic [DATA_WIDTH-1:0] coeff_t;

    localparam coeff_t ONE_M = coeff_t'((2 ** DATA_WIDTH) % Q);

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } inv_state_t;
endpackage

// File: rtl/mo_inv_if.sv
// Operand/result handshake bundle of the inverter: operand in, result out.
interface mo_inv_if
    import mo_inv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/mo_mul.sv
// Radix-2 Montgomery multiplier r = a*b*2^-WIDTH mod Q, one operand bit per pipeline stage.
// Operands must be held stable for WIDTH+1 cycles; r is valid during the last of them.
module mo_mul
    import mo_inv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r
);
    // Two guard bits: the running sum stays below 4Q before halving.
    localparam int TW = WIDTH + 2;
    localparam logic [TW-1:0] Q_T = TW'(Q);

    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        logic [TW-1:0] prev;
        logic [TW-1:0] sum;
        logic [TW-1:0] t_d;
        logic [TW-1:0] t_q;

        if (k == 0) begin : g_head
            assign prev = '0;
        end else begin : g_tail
            assign prev = g_stage[k-1].t_q;
        end

        always_comb begin
            sum = prev + (a[k] ? {2'b00, b} : '0);
            t_d = (sum + (sum[0] ? Q_T : '0)) >> 1;
        end

        always_ff @(posedge clk) begin
            t_q <= t_d;
        end
    end

    logic [TW-1:0] t_fin;
    assign t_fin = g_stage[WIDTH-1].t_q;
    assign r     = WIDTH'((t_fin >= Q_T) ? t_fin - Q_T : t_fin);
endmodule

// File: rtl/mo_inv.sv
// Sequential Montgomery-domain inverter: aR -> a^-1 R via a^(Q-2), left-to-right
// square-and-multiply on one shared mo_mul.
module mo_inv
    import mo_inv_pkg::*;
#(
    parameter int WIDTH    = DATA_WIDTH,
    parameter int EXP      = Q - 2,
    parameter int EXP_BITS = DATA_WIDTH,
    parameter int MUL_LAT  = DATA_WIDTH + 1
) (
    input logic     clk,
    input logic     rst_n,
    mo_inv_if.slave bus
);
    localparam int BW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [EXP_BITS-1:0] EXP_VEC  = EXP_BITS'(EXP);
    localparam logic [BW-1:0]       BIT_TOP  = BW'(EXP_BITS - 1);
    localparam logic [CW-1:0]       CNT_LAST = CW'(MUL_LAT - 1);
    localparam logic [WIDTH:0]      Q_EXT    = (WIDTH + 1)'(Q);

    inv_state_t       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] mul_b, mul_r;
    logic [WIDTH:0]   acc_ext;
    logic             last;

    assign mul_b   = (state_q == MUL) ? base_q : acc_q;
    assign acc_ext = {1'b0, acc_q};
    assign last    = (cnt_q == CNT_LAST);

    mo_mul #(.WIDTH(WIDTH)) u_mul (
        .clk (clk),
        .a   (acc_q),
        .b   (mul_b),
        .r   (mul_r)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        base_d      = base_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    base_d     = bus.in_data;
                    acc_d      = WIDTH'(ONE_M);
                    bit_d      = BIT_TOP;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SQR;
                end
            end
            SQR, MUL: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    acc_d = mul_r;
                    if (state_q == SQR && EXP_VEC[bit_q]) begin
                        state_d = MUL;
                    end else if (bit_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = SQR;
                    end
                end
            end
            DONE: begin
                // First DONE cycle publishes the canonical result; later cycles wait for drain.
                if (!out_valid_q) begin
                    out_data_d  = WIDTH'((acc_ext >= Q_EXT) ? acc_ext - Q_EXT : acc_ext);
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            base_q      <= '0;
            bit_q       <= BIT_TOP;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_mo_inv.sv
// Scoreboard bench for mo_inv: expected inverses come from a brute-force modular model.
module tb_mo_inv;
    localparam int Q     = 3329;
    localparam int W     = 12;
    localparam int R     = 4096;
    localparam int N_OPS = W + $countones(12'(Q - 2));
    localparam int LAT   = N_OPS * (W + 1) + 1;

    logic clk;
    logic rst_n;
    mo_inv_if #(.WIDTH(W)) bus ();

    mo_inv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    longint cyc    = 0;
    int     exp_q[$];
    longint cyc_q[$];
    bit     seen   = 0;
    int     r_inv;
    int     mon_e;
    longint mon_c;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint expv);
        n_chk++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    endtask

    function automatic int inv_mod(input int x);
        for (int y = 1; y < Q; y++)
            if ((x * y) % Q == 1) return y;
        return 0;
    endfunction

    // Leave the Montgomery domain, invert the plain value, and come back.
    function automatic int model(input int d);
        int x;
        x = (d * r_inv) % Q;
        if (x == 0) return 0;
        return (inv_mod(x) * R) % Q;
    endfunction

    // Monitor: pops one expectation on each rising out_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (bus.out_valid && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                check("out_data", bus.out_data, mon_e);
                check("latency", cyc - mon_c, LAT);
                check("out_range", (bus.out_data < Q) ? 1 : 0, 1);
            end
        end else if (!bus.out_valid) begin
            seen = 0;
        end
    end

    task automatic accept(input int d);
        int n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1;
        bus.in_data  = W'(d);
        @(posedge clk);
        #1;
        exp_q.push_back(model(d));
        cyc_q.push_back(cyc);
        bus.in_valid = 0;
    endtask

    task automatic drain(input int hold);
        int n = 0;
        logic [W-1:0] held;
        bus.out_ready = 0;
        while (!bus.out_valid && n < LAT + 20) begin
            @(negedge clk);
            n++;
            if (!bus.out_valid) begin
                check("busy_in_ready", bus.in_ready, 0);
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = W'($urandom_range(0, Q - 1));
            end
        end
        bus.in_valid = 0;
        check("result_timeout", bus.out_valid, 1);
        held = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, held);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1;
        @(negedge clk);
        check("drain_valid", bus.out_valid, 0);
        check("drain_in_ready", bus.in_ready, 1);
        bus.out_ready = 0;
    endtask

    initial begin
        int x;
        r_inv         = inv_mod(R % Q);
        rst_n         = 0;
        bus.in_valid  = 0;
        bus.in_data   = '0;
        bus.out_ready = 0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Directed: identity with long backpressure, 2^-1, (-1)^-1, zero.
        accept(767);  drain(50);
        accept(1534); drain(0);
        accept(2562); drain(3);
        accept(0);    drain(1);

        // Reset in the middle of a computation discards it.
        accept(2562);
        repeat (100) @(negedge clk);
        rst_n = 0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_data", bus.out_data, 0);
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        accept(1534); drain(0);

        for (int i = 0; i < 200; i++) begin
            x = $urandom_range(1, Q - 1);
            accept((x * R) % Q);
            drain($urandom_range(0, 3));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
